muldiv_unit: RTL and testbench

//  Iterative RV64M multiply/divide unit in the execute stage, beside the ALU.

---
 rtl/muldiv_unit_if.sv | 31 +++
 rtl/muldiv_unit.sv | 211 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between ID/EX, the muldiv unit and the EX/MEM side.
// master: issue side plus consumer (drives operands, flush, out_ready).
// slave: the unit itself (drives in_ready, out_valid, result, dst, dst_valid).
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            is_word;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [4:0]      dst_in;
    logic            wen_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [4:0]      dst;
    logic            dst_valid;

    modport master (
        output flush, in_valid, op, is_word, src_a, src_b, dst_in, wen_in, out_ready,
        input  in_ready, out_valid, result, dst, dst_valid
    );

    modport slave (
        input  flush, in_valid, op, is_word, src_a, src_b, dst_in, wen_in, out_ready,
        output in_ready, out_valid, result, dst, dst_valid
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Latency: accept in cycle 0 -> out_valid in cycle N+1 (N=64, or 32 for word ops); cycle 1 for div special cases.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush squashes any state.
module muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [CNT_W-1:0] LAST_D = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(31);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // ---------------- issue-side decode (combinational on bus inputs) ----------------
    logic [2:0]      op_eff;
    logic            is_div, div_uns, is_rem;
    logic            a_sgn, b_sgn, a_neg, b_neg, neg_res;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic            accept;

    // Fold word MULH* onto MULW, extend operands, take magnitudes and detect div special cases
    always_comb begin
        op_eff = bus.op;
        if (bus.is_word && (bus.op inside {OP_MULH, OP_MULHSU, OP_MULHU}))
            op_eff = OP_MUL;

        is_div  = op_eff[2];
        div_uns = is_div && op_eff[0];
        is_rem  = is_div && op_eff[1];

        if (bus.is_word && div_uns) begin
            a_ext = {{(XLEN-32){1'b0}}, bus.src_a[31:0]};
            b_ext = {{(XLEN-32){1'b0}}, bus.src_b[31:0]};
        end else if (bus.is_word) begin
            a_ext = sext_w(bus.src_a);
            b_ext = sext_w(bus.src_b);
        end else begin
            a_ext = bus.src_a;
            b_ext = bus.src_b;
        end

        a_sgn = op_eff inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_sgn = op_eff inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        a_neg = a_sgn && a_ext[XLEN-1];
        b_neg = b_sgn && b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        case (op_eff)
            OP_MUL, OP_MULH, OP_DIV: neg_res = a_neg ^ b_neg;
            OP_MULHSU, OP_REM:       neg_res = a_neg;
            default:                 neg_res = 1'b0;
        endcase

        min_val  = bus.is_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (b_ext == '0);
        div_ovf  = is_div && !div_uns && (a_ext == min_val) && (b_ext == '1);
        special  = div_zero || div_ovf;

        if (div_zero)
            special_res = is_rem ? a_ext : '1;
        else
            special_res = is_rem ? '0 : a_ext;
        if (bus.is_word)
            special_res = sext_w(special_res);

        accept = bus.in_valid && (state == IDLE) && !bus.flush;
    end

    // ---------------- iteration datapath ----------------
    logic [2:0]        op_q;
    logic              word_q, neg_q, wen_q;
    logic [4:0]        dst_q;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] mcand, prod;
    logic [XLEN-1:0]   mplier, dvsr, rem, quo;
    logic [XLEN-1:0]   result_q;

    logic [2*XLEN-1:0] prod_nxt, prod_fix;
    logic [XLEN:0]     rem_sh, rem_sub;
    logic              q_bit, last;
    logic [XLEN-1:0]   rem_nxt, quo_nxt, rem_fix, quo_fix, raw_res, calc_res;

    // One multiply step and one restoring-divide step, plus the final sign fixup
    always_comb begin
        prod_nxt = mplier[0] ? (prod + mcand) : prod;

        rem_sh   = {rem, quo[XLEN-1]};
        rem_sub  = rem_sh - {1'b0, dvsr};
        q_bit    = !rem_sub[XLEN];
        rem_nxt  = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nxt  = {quo[XLEN-2:0], q_bit};

        prod_fix = neg_q ? -prod_nxt : prod_nxt;
        quo_fix  = neg_q ? -quo_nxt : quo_nxt;
        rem_fix  = neg_q ? -rem_nxt : rem_nxt;

        case (op_q)
            OP_MUL:                        raw_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  raw_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               raw_res = quo_fix;
            default:                       raw_res = rem_fix;
        endcase
        calc_res = word_q ? sext_w(raw_res) : raw_res;

        last = (cnt == (word_q ? LAST_W : LAST_D));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: flush wins everywhere, specials bypass CALC
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid) state_nxt = special ? DONE : CALC;
                CALC:    if (last)         state_nxt = DONE;
                DONE:    if (bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand latch on accept, per-cycle iteration in CALC, result load at the last step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_MUL;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            wen_q    <= 1'b0;
            dst_q    <= '0;
            cnt      <= '0;
            mcand    <= '0;
            prod     <= '0;
            mplier   <= '0;
            dvsr     <= '0;
            rem      <= '0;
            quo      <= '0;
            result_q <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (accept) begin
            op_q   <= op_eff;
            word_q <= bus.is_word;
            neg_q  <= neg_res;
            wen_q  <= bus.wen_in;
            dst_q  <= bus.dst_in;
            cnt    <= '0;
            mcand  <= {{XLEN{1'b0}}, a_mag};
            prod   <= '0;
            mplier <= b_mag;
            dvsr   <= b_mag;
            rem    <= '0;
            // word dividends are pre-shifted so their bit 31 is the first one shifted out
            quo    <= bus.is_word ? (a_mag << 32) : a_mag;
            if (special)
                result_q <= special_res;
        end else if (state == CALC) begin
            prod   <= prod_nxt;
            mcand  <= {mcand[2*XLEN-2:0], 1'b0};
            mplier <= {1'b0, mplier[XLEN-1:1]};
            rem    <= rem_nxt;
            quo    <= quo_nxt;
            if (last) begin
                cnt      <= '0;
                result_q <= calc_res;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Outputs decoded from state; dst_valid is the forwarding qualifier
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.dst_valid = (state == DONE) && wen_q && (dst_q != 5'd0);
        bus.result    = result_q;
        bus.dst       = dst_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with a queue scoreboard.
// The issue side pushes the expected result and latency; a negedge monitor checks out_valid timing and pops on handshake.
// Extra directed phases cover backpressure, flush and asynchronous reset.
module tb_muldiv_unit;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN), .CNT_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  dst;
        logic        dv;
        int          hs;
        int          lat;
    } exp_t;

    exp_t q[$];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: latency on out_valid rise, result/dst/dst_valid on handshake
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            ov_prev = 1'b0;
        end else begin
            if (bus.out_valid && !ov_prev) begin
                if (q.size() == 0)
                    check_int("unexpected_out_valid", 1, 0);
                else
                    check_int("latency", cyc - q[0].hs, q[0].lat);
            end
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check64("result", bus.result, e.res);
                check_int("dst", int'(bus.dst), int'(e.dst));
                check_int("dst_valid", int'(bus.dst_valid), int'(e.dv));
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] d, input logic wn,
                         input logic [63:0] exp, input int lat, input bit push,
                         output int hs);
        int waited;
        exp_t e;
        waited = 0;
        hs = -1;
        @(negedge clk);
        bus.op = op; bus.is_word = w; bus.src_a = a; bus.src_b = b;
        bus.dst_in = d; bus.wen_in = wn; bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check_int("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        hs = cyc;
        if (push) begin
            e.res = exp; e.dst = d; e.dv = wn && (d != 5'd0); e.hs = hs; e.lat = lat;
            q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int hs;
        int waited;
        int seen;

        reset = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = 3'd0; bus.is_word = 1'b0;
        bus.src_a = '0; bus.src_b = '0; bus.dst_in = '0; bus.wen_in = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_int("rst_in_ready", int'(bus.in_ready), 1);
        check_int("rst_out_valid", int'(bus.out_valid), 0);
        check_int("rst_dst_valid", int'(bus.dst_valid), 0);
        check64("rst_result", bus.result, 64'd0);
        check_int("rst_dst", int'(bus.dst), 0);
        reset = 1'b0;

        // op, word, a, b, dst, wen, expected, latency
        issue(3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 1, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1, hs);
        issue(3'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 1, 64'd1, 65, 1, hs);
        issue(3'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1, 64'd0, 65, 1, hs);
        issue(3'd4, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1, 64'h8000_0000_0000_0000, 1, 1, hs);
        issue(3'd6, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1, 64'd0, 1, 1, hs);
        issue(3'd5, 0, 64'd5, 64'd0, 5'd10, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, hs);
        issue(3'd7, 0, 64'd5, 64'd0, 5'd11, 1, 64'd5, 1, 1, hs);
        issue(3'd4, 1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd12, 1, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1, hs);
        issue(3'd6, 1, 64'h0000_0001_FFFF_FFF9, 64'd2, 5'd13, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1, hs);
        issue(3'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd14, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1, hs);
        issue(3'd4, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd15, 1, 64'hFFFF_FFFF_FFFF_FFF2, 65, 1, hs);
        issue(3'd6, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd16, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1, hs);
        issue(3'd0, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd17, 1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1, hs);
        issue(3'd3, 1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd18, 1, 64'hFFFF_FFFF_FFFF_FFFE, 33, 1, hs);
        issue(3'd4, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd19, 1, 64'hFFFF_FFFF_8000_0000, 1, 1, hs);
        issue(3'd5, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd20, 1, 64'h0000_0000_0FFF_FFFF, 33, 1, hs);
        issue(3'd5, 0, 64'd5, 64'd0, 5'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, hs);
        issue(3'd5, 0, 64'd5, 64'd0, 5'd21, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, hs);

        // Backpressure: result parked in DONE for 20 cycles
        @(posedge clk); #1 bus.out_ready = 1'b0;
        issue(3'd5, 0, 64'd100, 64'd7, 5'd22, 1, 64'd14, 65, 1, hs);
        waited = 0;
        while (!bus.out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_int("bp_out_valid", int'(bus.out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check64("bp_result", bus.result, 64'd14);
            check_int("bp_dst", int'(bus.dst), 22);
            check_int("bp_dst_valid", int'(bus.dst_valid), 1);
            check_int("bp_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Flush together with in_valid in IDLE: nothing accepted
        bus.op = 3'd0; bus.src_a = 64'd9; bus.src_b = 64'd9; bus.dst_in = 5'd3;
        bus.wen_in = 1'b1; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check_int("flush_idle_in_ready", int'(bus.in_ready), 1);
        check_int("flush_idle_out_valid", int'(bus.out_valid), 0);

        // Flush in CALC cycle 10: op vanishes, unit free next cycle
        issue(3'd0, 0, 64'd11, 64'd13, 5'd23, 1, 64'd143, 65, 0, hs);
        while (cyc < hs + 10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check_int("flush_calc_in_ready", int'(bus.in_ready), 1);
        check_int("flush_calc_out_valid", int'(bus.out_valid), 0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_int("flush_no_out_valid", seen, 0);
        issue(3'd0, 0, 64'd3, 64'd4, 5'd24, 1, 64'd12, 65, 1, hs);

        // Asynchronous reset in the middle of CALC
        issue(3'd0, 0, 64'd3, 64'd5, 5'd25, 1, 64'd15, 65, 0, hs);
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_int("arst_in_ready", int'(bus.in_ready), 1);
        check_int("arst_out_valid", int'(bus.out_valid), 0);
        check_int("arst_dst_valid", int'(bus.dst_valid), 0);
        check64("arst_result", bus.result, 64'd0);
        check_int("arst_dst", int'(bus.dst), 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_int("arst_no_out_valid", seen, 0);

        waited = 0;
        while (q.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_int("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
